// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the multicycle MIPS control path: FETCH/EXEC phasing,
// next-address selection with optional branch delay slot, and sticky halt on the exit address.
module pc_sequencer #(
   parameter int               ADDR_W       = 32,
   parameter logic [31:0]      RESET_VECTOR = 32'hBFC00000,
   parameter logic [ADDR_W-1:0] EXIT_ADDR   = '0,
   parameter bit               DELAY_SLOT   = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [1:0]        redirect_kind,
   input  logic [ADDR_W-1:0] reg_target,
   input  logic [25:0]       imm26,
   input  logic [15:0]       imm16,
   output logic [ADDR_W-1:0] addr,
   output logic              exec_phase,
   output logic              fetch_en,
   output logic              delay_slot,
   output logic [ADDR_W-1:0] link_addr,
   output logic              finish
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

   localparam logic [ADDR_W-1:0] LINK_OFS = DELAY_SLOT ? ADDR_W'(8) : ADDR_W'(4);

   state_t            state;
   logic              pend_valid;
   logic [ADDR_W-1:0] pend_target;

   logic [ADDR_W-1:0] seq;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] next_addr;
   logic              next_pend_valid;
   logic              take;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      seq    = addr + ADDR_W'(4);
      target = seq;
      case (redirect_kind)
         2'b01:   target = reg_target;
         2'b10:   target[27:0] = {imm26, 2'b00};
         2'b11:   target = seq + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};
         default: target = seq;
      endcase

      // A redirect arriving while a delay-slot instruction executes is dropped.
      take            = redirect_valid && (redirect_kind != 2'b00) && !pend_valid;
      next_addr       = seq;
      next_pend_valid = 1'b0;
      if (DELAY_SLOT) begin
         if (take) begin
            next_pend_valid = 1'b1;
         end else if (pend_valid) begin
            next_addr = pend_target;
         end
      end else if (take) begin
         next_addr = target;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_FETCH;
         addr       <= ADDR_W'(RESET_VECTOR);
         pend_valid <= 1'b0;
         finish     <= 1'b0;
      end else if (!stall) begin
         case (state)
            S_FETCH: state <= S_EXEC;
            S_EXEC: begin
               addr       <= next_addr;
               pend_valid <= next_pend_valid;
               if (next_addr == EXIT_ADDR) begin
                  state  <= S_HALT;
                  finish <= 1'b1;
               end else begin
                  state <= S_FETCH;
               end
            end
            default: state <= S_HALT;
         endcase
      end
   end

   // NOTE: pend_target has no reset; it is only ever read while pend_valid is set.
   always_ff @(posedge clk) begin
      if (!reset && !stall && state == S_EXEC && DELAY_SLOT && take) begin
         pend_target <= target;
      end
   end

   assign exec_phase = (state == S_EXEC);
   assign fetch_en   = (state == S_FETCH);
   assign delay_slot = pend_valid;
   assign link_addr  = addr + LINK_OFS;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer for the multicycle MIPS control path. It owns the FETCH/EXEC phase machine, computes the next fetch address from sequential, register-absolute, page-absolute and PC-relative redirects, and optionally models the MIPS branch delay slot. It also detects the exit address and raises a sticky `finish`. Instruction decode and branch-condition evaluation stay upstream; this block only sees a qualified redirect request.

## Interface
- `ADDR_W`, 32: address width; must be ≥ 28.
- `RESET_VECTOR`, 32'hBFC00000: `addr` after reset (truncated to `ADDR_W`).
- `EXIT_ADDR`, 0: fetch address that halts the machine.
- `DELAY_SLOT`, 1: 1 = one-instruction delay slot after every redirect; 0 = redirect takes effect immediately.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `stall`  in  1  freeze the phase, PC and pending state this cycle.
- `redirect_valid`  in  1  taken jump/branch; sampled only in EXEC.
- `redirect_kind`  in  2  01 register-absolute, 10 page-absolute, 11 PC-relative; 00 treated as no redirect.
- `reg_target`  in  ADDR_W  register value for JR/JALR.
- `imm26`  in  26  J/JAL index.
- `imm16`  in  16  branch offset, signed.
- `addr`  out  ADDR_W  current instruction address.
- `exec_phase`  out  1  0 = FETCH, 1 = EXEC.
- `fetch_en`  out  1  FETCH phase and not halted.
- `delay_slot`  out  1  the current instruction is a delay-slot instruction.
- `link_addr`  out  ADDR_W  return address: `addr`+8 when `DELAY_SLOT`=1, `addr`+4 when 0.
- `finish`  out  1  sticky halt indicator.

## Operation
- FSM states are FETCH, EXEC and HALT.
  - FETCH→EXEC on any non-stalled cycle.
  - EXEC→FETCH on any non-stalled cycle, and `addr` updates on that transition.
  - Entering FETCH with the new `addr` == `EXIT_ADDR` goes to HALT instead.
  - HALT is terminal until reset.
- `seq` = `addr`+4, modulo 2^ADDR_W.
- Target computation (all arithmetic modulo 2^ADDR_W):
  - kind 01: `reg_target`.
  - kind 10: {`seq`[ADDR_W-1:28], `imm26`, 2'b00}.
  - kind 11: `seq` + (sign-extended `imm16` << 2).
- Next address when `DELAY_SLOT`=1:
  - Accepted redirect: `addr` ← `seq`, `pend_target` ← target, `pend_valid` ← 1.
  - Otherwise, if `pend_valid`: `addr` ← `pend_target`, `pend_valid` ← 0.
  - Otherwise: `addr` ← `seq`.
- Next address when `DELAY_SLOT`=0: `addr` ← target if a redirect is accepted, else `seq`. `pend_valid` stays 0.
- `delay_slot` = `pend_valid`.
- A redirect presented while `delay_slot`=1 is ignored. The pending target wins and no new pending entry is created.
- `stall`=1 holds every register, including `finish` and the phase, regardless of other inputs.
- In HALT, `finish`=1, `fetch_en`=0, `exec_phase`=0, `addr` holds `EXIT_ADDR`, and redirects and stalls are ignored.
- An exit via `DELAY_SLOT`=1 still executes the delay-slot instruction before halting, because halting is decided when the jump target reaches `addr`.

## Timing
- Reset values:
  - `addr`=`RESET_VECTOR`, phase FETCH.
  - `fetch_en`=1, `exec_phase`=0.
  - `delay_slot`=0, `pend_valid`=0.
  - `finish`=0.
  - `link_addr`=`RESET_VECTOR`+8 (or +4 when `DELAY_SLOT`=0).
- Reset takes priority over `stall`.
- Reset mid-operation discards the pending redirect and any halt.
- An unstalled instruction takes 2 cycles: FETCH then EXEC. `addr` changes on the clock edge that ends EXEC.
- The redirect inputs, `reg_target`, `imm26` and `imm16` must be stable in the EXEC cycle in which the edge occurs. Values in the FETCH cycle are don't-care.
- `link_addr`, `fetch_en`, `exec_phase` and `delay_slot` are combinational from registered state.
- `finish` rises on the same edge that loads `EXIT_ADDR` into `addr`.
- A stall in EXEC with `redirect_valid`=1 does not consume the redirect. It is accepted on the first unstalled EXEC edge.

## Test plan
- **Sequential run:** reset, then 3 unstalled instructions → `addr` sequence BFC00000, BFC00004, BFC00008, BFC0000C, with 2 cycles per address; `link_addr`=BFC00008 during the first instruction.
- **Relative branch with delay slot:** at `addr`=BFC00010, kind 11, `imm16`=16'hFFFC → next BFC00014 with `delay_slot`=1, then BFC00004. With `imm16`=16'h0003 the final address is BFC00020.
- **Page and register jumps:**
  - At `addr`=BFC00100, kind 10, `imm26`=26'h0000040 → BFC00104, then B0000100.
  - Kind 01 with `reg_target`=0 → delay slot at `addr`+4, then `addr`=0, `finish`=1, `fetch_en`=0 held for 20 cycles despite toggling redirects.
- **Stall:** assert `stall` for 5 cycles during EXEC with a redirect held → `addr`, phase and `delay_slot` unchanged; the redirect is applied after release.
- **Boundary cases:**
  - A redirect during the delay slot is ignored, and the original target is reached.
  - `addr`=FFFFFFFC sequential step wraps to 0 and halts.
  - Reset asserted while `pend_valid`=1 → `addr`=BFC00000, `delay_slot`=0.
- **DELAY_SLOT=0 build:** kind 11 with `imm16`=16'h0002 at BFC00000 → next `addr`=BFC0000C directly, `delay_slot` never asserts, `link_addr`=`addr`+4.
